tile_renderer: RTL and testbench

- Pipelined tile-plane pixel generator for the video path.
- Holds a writable tile map; each cell stores tile type, 2-bit rotation and a mirror flag.
- Per pixel, looks up the cell under (hpos, vpos), transforms local coordinates, fetches the glyph row from a parametrised glyph ROM, and emits a colour after fixed latency.
- Successor to the fixed 8x8, 4-type combinational tile lookup: adds parametrised tile size, map storage, mirroring, pipelining and a reset-time map-clear sequencer.

---
 rtl/tile_pkg.sv | 8 +
 rtl/tile_renderer_if.sv | 29 ++
 rtl/tile_glyph_rom.sv | 23 ++
 rtl/tile_renderer.sv | 83 ++++++++
 tb/tb_tile_renderer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// tile_pkg: shared encodings and map cell layout for the tile renderer
package tile_pkg;
  typedef enum logic [1:0] {ROT_0 = 2'd0, ROT_90 = 2'd1, ROT_180 = 2'd2, ROT_270 = 2'd3} rot_t;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;
  function automatic int cell_bits(input int type_bits);
    return type_bits + 3;
  endfunction
endpackage

// File: rtl/tile_renderer_if.sv
// tile_renderer_if: pixel position stream, map write port and colour output
interface tile_renderer_if #(
  parameter int TILE_BITS = 3,
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 5,
  parameter int TYPE_BITS = 2,
  parameter int COLOR_BITS = 3
);
  logic [TILE_BITS+COL_BITS-1:0] hpos;
  logic [TILE_BITS+ROW_BITS-1:0] vpos;
  logic display_on;
  logic wr_en;
  logic [COL_BITS-1:0] wr_col;
  logic [ROW_BITS-1:0] wr_row;
  logic [TYPE_BITS-1:0] wr_type;
  logic [1:0] wr_rot;
  logic wr_mirror;
  logic wr_ready;
  logic [COLOR_BITS-1:0] rgb;
  logic pixel_valid;
  modport master(
    output hpos, vpos, display_on, wr_en, wr_col, wr_row, wr_type, wr_rot, wr_mirror,
    input wr_ready, rgb, pixel_valid
  );
  modport slave(
    input hpos, vpos, display_on, wr_en, wr_col, wr_row, wr_type, wr_rot, wr_mirror,
    output wr_ready, rgb, pixel_valid
  );
endinterface

// File: rtl/tile_glyph_rom.sv
// tile_glyph_rom: combinational glyph row lookup, MSB is the leftmost pixel
module tile_glyph_rom #(
  parameter int TILE_BITS = 3,
  parameter int TYPE_BITS = 2
) (
  input  logic [TYPE_BITS-1:0] tile_type,
  input  logic [TILE_BITS-1:0] row,
  output logic [2**TILE_BITS-1:0] word
);
  if (TILE_BITS == 3) begin : g_8x8
    int t, r;
    always_comb begin
      t = 32'(tile_type);
      r = 32'(row);
      word = t == 1 ? 8'b0001_0000 :
             t == 2 ? (r < 3 ? 8'b0 : r == 3 ? 8'b1110_0000 : 8'b0001_0000) :
             t == 3 ? (r < 4 ? 8'b0 : r == 4 ? 8'b1100_0000 : r == 5 ? 8'b0010_0000 : 8'b0001_0000) :
             8'b0;
    end
  end else begin : g_blank
    assign word = '0;
  end
endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: 2-stage tile-plane pixel generator with writable map and reset-time clear
module tile_renderer
  import tile_pkg::*;
#(
  parameter int TILE_BITS = 3,
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 5,
  parameter int TYPE_BITS = 2,
  parameter int COLOR_BITS = 3,
  parameter int FG_COLOR = 4,
  parameter int BG_COLOR = 0
) (
  input logic clk,
  input logic reset,
  tile_renderer_if.slave bus
);
  localparam int N = 2**TILE_BITS;
  localparam int AB = COL_BITS + ROW_BITS;
  localparam int CW = cell_bits(TYPE_BITS);
  logic [CW-1:0] tile_map [2**AB];
  state_t state, state_n;
  logic [AB-1:0] clr_addr, clr_addr_n, waddr;
  logic we;
  logic [CW-1:0] wdata;
  logic [CW-1:0] cell_q;
  logic [TILE_BITS-1:0] lx_q, ly_q, x1, gx, gy;
  logic de_q;
  logic [TYPE_BITS-1:0] ctype;
  logic [1:0] crot;
  logic cmir;
  logic [N-1:0] glyph_row;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_n;
      clr_addr <= clr_addr_n;
    end
  end
  // CLEAR owns the write port; user writes arriving then are dropped
  always_comb begin
    state_n = state;
    clr_addr_n = clr_addr;
    we = 1'b0;
    waddr = clr_addr;
    wdata = '0;
    if (state == CLEAR) begin
      we = !reset;
      clr_addr_n = clr_addr + 1'b1;
      state_n = &clr_addr ? RUN : CLEAR;
    end else begin
      we = bus.wr_en && !reset;
      waddr = {bus.wr_row, bus.wr_col};
      wdata = {bus.wr_mirror, bus.wr_rot, bus.wr_type};
    end
  end
  assign bus.wr_ready = state == RUN;
  always_ff @(posedge clk) if (we) tile_map[waddr] <= wdata;
  assign {cmir, crot, ctype} = cell_q;
  assign x1 = cmir ? ~lx_q : lx_q;
  assign gx = crot == ROT_0 ? x1 : crot == ROT_90 ? ly_q : crot == ROT_180 ? ~x1 : ~ly_q;
  assign gy = crot == ROT_0 ? ly_q : crot == ROT_90 ? ~x1 : crot == ROT_180 ? ~ly_q : x1;
  tile_glyph_rom #(.TILE_BITS(TILE_BITS), .TYPE_BITS(TYPE_BITS)) u_rom (
    .tile_type(ctype),
    .row(gy),
    .word(glyph_row)
  );
  always_ff @(posedge clk) begin
    cell_q <= tile_map[{bus.vpos[TILE_BITS+:ROW_BITS], bus.hpos[TILE_BITS+:COL_BITS]}];
    lx_q <= bus.hpos[TILE_BITS-1:0];
    ly_q <= bus.vpos[TILE_BITS-1:0];
    if (reset) begin
      de_q <= 1'b0;
      bus.rgb <= COLOR_BITS'(BG_COLOR);
      bus.pixel_valid <= 1'b0;
    end else begin
      de_q <= bus.display_on;
      bus.rgb <= de_q && glyph_row[~gx] ? COLOR_BITS'(FG_COLOR) : COLOR_BITS'(BG_COLOR);
      bus.pixel_valid <= de_q;
    end
  end
endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer: randomized and directed checks against an array-based map/glyph model
module tb_tile_renderer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  tile_renderer_if bus ();
  tile_renderer dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int m_type[1024], m_rot[1024], m_mir[1024];
  bit known[1024];
  bit m_ready = 0;
  int m_cnt = 0;
  bit armed = 0;
  int d1_rgb = 0, d1_pv = 0, out_rgb = 0, out_pv = 0;
  bit d1_care = 0, out_care = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit glyph(input int t, input int r, input int c);
    case (t)
      1: return c == 3;
      2: return (r == 3 && c < 3) || (r >= 4 && c == 3);
      3: return (r == 4 && c < 2) || (r == 5 && c == 2) || (r >= 6 && c == 3);
      default: return 0;
    endcase
  endfunction

  function automatic bit pix_set(input int a, input int x, input int y);
    int gx, gy, xm;
    xm = m_mir[a] != 0 ? 7 - x : x;
    case (m_rot[a])
      0: begin gx = xm; gy = y; end
      1: begin gx = y; gy = 7 - xm; end
      2: begin gx = 7 - xm; gy = 7 - y; end
      default: begin gx = 7 - y; gy = xm; end
    endcase
    return glyph(m_type[a], gy, gx);
  endfunction

  always @(posedge clk) begin
    int a, h, v;
    h = int'(bus.hpos);
    v = int'(bus.vpos);
    a = (v / 8) * 32 + h / 8;
    if (reset) begin
      armed = 1;
      out_rgb = 0; out_pv = 0; out_care = 1;
    end else begin
      out_rgb = d1_rgb; out_pv = d1_pv; out_care = d1_care;
    end
    d1_pv = (!reset && bus.display_on) ? 1 : 0;
    d1_care = reset || !bus.display_on || known[a];
    d1_rgb = (!reset && bus.display_on && known[a] && pix_set(a, h % 8, v % 8)) ? 4 : 0;
    if (reset) begin
      m_ready = 0;
      m_cnt = 0;
    end else if (!m_ready) begin
      m_type[m_cnt] = 0; m_rot[m_cnt] = 0; m_mir[m_cnt] = 0; known[m_cnt] = 1;
      m_cnt++;
      if (m_cnt == 1024) m_ready = 1;
    end else if (bus.wr_en) begin
      a = int'(bus.wr_row) * 32 + int'(bus.wr_col);
      m_type[a] = int'(bus.wr_type); m_rot[a] = int'(bus.wr_rot); m_mir[a] = int'(bus.wr_mirror);
      known[a] = 1;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("wr_ready", int'(bus.wr_ready), int'(m_ready));
    chk("pixel_valid", int'(bus.pixel_valid), out_pv);
    if (out_care) chk("rgb", int'(bus.rgb), out_rgb);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 0; bus.wr_col = 0; bus.wr_row = 0; bus.wr_type = 0; bus.wr_rot = 0; bus.wr_mirror = 0;
    bus.hpos = 0; bus.vpos = 0; bus.display_on = 0;
  endtask

  task automatic rand_stim(input bit writes);
    bus.wr_en = writes && $urandom_range(0, 3) == 0;
    bus.wr_col = 5'($urandom); bus.wr_row = 5'($urandom);
    bus.wr_type = 2'($urandom); bus.wr_rot = 2'($urandom); bus.wr_mirror = 1'($urandom);
    bus.hpos = 8'($urandom); bus.vpos = 8'($urandom);
    bus.display_on = $urandom_range(0, 7) != 0;
  endtask

  task automatic wr(input int col, input int row, input int t, input int rot, input int mir);
    bus.wr_en = 1; bus.wr_col = 5'(col); bus.wr_row = 5'(row);
    bus.wr_type = 2'(t); bus.wr_rot = 2'(rot); bus.wr_mirror = 1'(mir);
    tick();
    bus.wr_en = 0;
  endtask

  task automatic pix(input int h, input int v, input int d, output int rgbv, output int pv);
    bus.hpos = 8'(h); bus.vpos = 8'(v); bus.display_on = 1'(d);
    tick();
    tick();
    rgbv = int'(bus.rgb);
    pv = int'(bus.pixel_valid);
  endtask

  task automatic count_clear(input bit drop_write);
    int cnt;
    cnt = 0;
    while (!bus.wr_ready && cnt < 2000) begin
      rand_stim(0);
      if (cnt < 2) bus.display_on = 0;
      if (drop_write && cnt == 10) begin
        bus.wr_en = 1; bus.wr_col = 0; bus.wr_row = 0; bus.wr_type = 2; bus.wr_rot = 0; bus.wr_mirror = 0;
      end
      tick();
      cnt++;
      if (cnt <= 2) begin
        chk("early_rgb", int'(bus.rgb), 0);
        chk("early_pv", int'(bus.pixel_valid), 0);
      end
    end
    chk("clear_len", cnt, 1024);
    idle();
  endtask

  initial begin
    int r, p;
    idle();
    repeat (2) tick();
    chk("reset_rgb", int'(bus.rgb), 0);
    chk("reset_pv", int'(bus.pixel_valid), 0);
    chk("reset_ready", int'(bus.wr_ready), 0);
    reset = 0;
    count_clear(1);
    pix(3, 4, 1, r, p);
    chk("dropped_write", r, 0);
    wr(2, 1, 1, 0, 0);
    for (int h = 16; h < 24; h++) begin
      pix(h, 8, 1, r, p);
      chk("vline_rot0", r, h == 19 ? 4 : 0);
    end
    wr(2, 1, 1, 1, 0);
    for (int v = 8; v < 16; v++) begin
      pix(16, v, 1, r, p);
      chk("vline_rot1", r, v == 11 ? 4 : 0);
    end
    wr(2, 1, 3, 0, 1);
    pix(22, 12, 1, r, p);
    chk("mirror_x6y4", r, 4);
    pix(16, 12, 1, r, p);
    chk("mirror_x0y4", r, 0);
    bus.hpos = 8'd43; bus.vpos = 8'd0; bus.display_on = 1;
    bus.wr_en = 1; bus.wr_col = 5; bus.wr_row = 0; bus.wr_type = 1; bus.wr_rot = 0; bus.wr_mirror = 0;
    tick();
    bus.wr_en = 0;
    tick();
    chk("rbw_old", int'(bus.rgb), 0);
    tick();
    chk("rbw_new", int'(bus.rgb), 4);
    pix(43, 0, 0, r, p);
    chk("blank_rgb", r, 0);
    chk("blank_pv", p, 0);
    repeat (3000) begin
      rand_stim(1);
      tick();
    end
    idle();
    reset = 1;
    tick();
    reset = 0;
    repeat (500) begin
      rand_stim(1);
      tick();
    end
    idle();
    reset = 1;
    tick();
    reset = 0;
    count_clear(0);
    repeat (500) begin
      rand_stim(1);
      tick();
    end
    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
